// File: rtl/musa_pc_pkg.sv
// Shared definitions for the MUSA program-counter unit: opcode encodings
// and the default address width.
package musa_pc_pkg;

   localparam int MUSA_ADDR_W = 18;

   // Next-PC operation selected by the control unit; code 7 is undefined
   // and behaves like OP_HOLD.
   typedef enum logic [2:0] {
      OP_NEXT = 3'd0,
      OP_JMP  = 3'd1,
      OP_JR   = 3'd2,
      OP_BRFL = 3'd3,
      OP_CALL = 3'd4,
      OP_RET  = 3'd5,
      OP_HOLD = 3'd6
   } pc_op_t;

endpackage

// File: rtl/musa_ras.sv
// Return-address stack: LIFO register array indexed by the depth register.
// Push while full and pop while empty are ignored here; the caller reports
// them as errors.
module musa_ras
   import musa_pc_pkg::*;
#(
   parameter int ADDR_W      = MUSA_ADDR_W,
   parameter int STACK_DEPTH = 8,
   parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push,
   input  logic               pop,
   input  logic [ADDR_W-1:0]  push_data,
   output logic [ADDR_W-1:0]  top,
   output logic [DEPTH_W-1:0] depth,
   output logic               full,
   output logic               empty
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

   logic [ADDR_W-1:0]  mem [STACK_DEPTH];
   logic [DEPTH_W-1:0] depth_q;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;
   logic               do_push;
   logic               do_pop;

   assign full    = (depth_q == FULL_DEPTH);
   assign empty   = (depth_q == '0);
   assign depth   = depth_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Next free slot is mem[depth]; the top entry sits one below it.
   assign wr_idx = IDX_W'(depth_q);
   assign rd_idx = IDX_W'(depth_q - DEPTH_W'(1));
   assign top    = empty ? '0 : mem[rd_idx];

   // Depth counter; reset empties the stack without touching the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         depth_q <= '0;
      else if (do_push)
         depth_q <= depth_q + DEPTH_W'(1);
      else if (do_pop)
         depth_q <= depth_q - DEPTH_W'(1);
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/musa_pc_unit.sv
// MUSA program-counter unit: PC register, next-PC selection, return stack
// and sticky stack-error flag.
// Build option: MUSA_PC_TRAP_EN -- when defined, a CALL overflow or RET
// underflow redirects the PC to TRAP_VEC; otherwise the PC holds.
module musa_pc_unit
   import musa_pc_pkg::*;
#(
   parameter int                ADDR_W      = MUSA_ADDR_W,
   parameter int                STACK_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'('h00010)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               stall,
   input  logic [2:0]                         pc_op,
   input  logic [ADDR_W-1:0]                  target_imm,
   input  logic [ADDR_W-1:0]                  target_reg,
   input  logic                               flag,
   input  logic                               clr_err,
   output logic [ADDR_W-1:0]                  pc,
   output logic                               stack_full,
   output logic                               stack_empty,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
   output logic                               stack_err
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

`ifdef MUSA_PC_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   pc_op_t            op;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] err_pc;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_push;
   logic              ras_pop;
   logic              ras_full;
   logic              ras_empty;
   logic              err_set;
   logic              err_q;

   assign op     = pc_op_t'(pc_op);
   assign pc_inc = pc_q + ADDR_W'(1);
   // Where the PC goes on a stack error: trap vector or stay put.
   assign err_pc = TRAP_EN ? TRAP_VEC : pc_q;

   // Stall suppresses stack traffic; the stack itself drops illegal ops.
   assign ras_push = ~stall & (op == OP_CALL);
   assign ras_pop  = ~stall & (op == OP_RET);

   musa_ras #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH),
      .DEPTH_W     (DEPTH_W)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .depth     (stack_depth),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   // Next-PC selection and stack-error detection from the current opcode.
   always_comb begin
      pc_nxt  = pc_q;
      err_set = 1'b0;
      case (op)
         OP_NEXT: pc_nxt = pc_inc;
         OP_JMP:  pc_nxt = target_imm;
         OP_JR:   pc_nxt = target_reg;
         OP_BRFL: pc_nxt = flag ? target_imm : pc_inc;
         OP_CALL: begin
            if (ras_full) begin
               err_set = 1'b1;
               pc_nxt  = err_pc;
            end else begin
               pc_nxt  = target_imm;
            end
         end
         OP_RET: begin
            if (ras_empty) begin
               err_set = 1'b1;
               pc_nxt  = err_pc;
            end else begin
               pc_nxt  = ras_top;
            end
         end
         default: pc_nxt = pc_q;
      endcase
   end

   // PC register; stall freezes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_q <= RESET_PC;
      else if (!stall)
         pc_q <= pc_nxt;
   end

   // Sticky error flag; a new error beats a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else if (!stall) begin
         if (err_set)
            err_q <= 1'b1;
         else if (clr_err)
            err_q <= 1'b0;
      end
   end

   assign pc          = pc_q;
   assign stack_err   = err_q;
   assign stack_full  = ras_full;
   assign stack_empty = ras_empty;

endmodule

// File: tb/tb_musa_pc_unit.sv
// Self-checking bench for musa_pc_unit: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_musa_pc_unit;
   import musa_pc_pkg::*;

   localparam int          AW    = 18;
   localparam int          DEPTH = 8;
   localparam logic [17:0] RST_PC = 18'h0;
   localparam logic [17:0] TRAP   = 18'h00010;
`ifdef MUSA_PC_TRAP_EN
   localparam bit TRAP_ON = 1'b1;
`else
   localparam bit TRAP_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic [2:0]    pc_op = 3'd6;
   logic [AW-1:0] target_imm = '0;
   logic [AW-1:0] target_reg = '0;
   logic          flag = 1'b0;
   logic          clr_err = 1'b0;
   logic [AW-1:0] pc;
   logic          stack_full;
   logic          stack_empty;
   logic [3:0]    stack_depth;
   logic          stack_err;

   int checks = 0;
   int failures = 0;

   // Reference model state
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_stk[$];
   logic          m_err;

   always #5 clk = ~clk;

   musa_pc_unit #(
      .ADDR_W(AW), .STACK_DEPTH(DEPTH), .RESET_PC(RST_PC), .TRAP_VEC(TRAP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .pc_op(pc_op),
      .target_imm(target_imm), .target_reg(target_reg), .flag(flag),
      .clr_err(clr_err), .pc(pc), .stack_full(stack_full),
      .stack_empty(stack_empty), .stack_depth(stack_depth),
      .stack_err(stack_err)
   );

   function automatic void model_reset();
      m_pc = RST_PC;
      m_stk.delete();
      m_err = 1'b0;
   endfunction

   // Architectural rules applied to the inputs seen at a clock edge.
   function automatic void model_step();
      logic [AW-1:0] inc;
      bit e;
      inc = m_pc + 18'd1;
      e = 0;
      if (stall) return;
      case (pc_op)
         3'd0: m_pc = inc;
         3'd1: m_pc = target_imm;
         3'd2: m_pc = target_reg;
         3'd3: m_pc = flag ? target_imm : inc;
         3'd4: if (m_stk.size() >= DEPTH) e = 1;
               else begin m_stk.push_back(inc); m_pc = target_imm; end
         3'd5: if (m_stk.size() == 0) e = 1;
               else m_pc = m_stk.pop_back();
         default: ;
      endcase
      if (e) begin
         m_err = 1'b1;
         if (TRAP_ON) m_pc = TRAP;
      end else if (clr_err) m_err = 1'b0;
   endfunction

   task automatic apply(input logic [2:0] op, input logic [AW-1:0] imm,
                        input logic [AW-1:0] rg, input logic f,
                        input logic st, input logic clr);
      @(negedge clk);
      pc_op = op; target_imm = imm; target_reg = rg;
      flag = f; stall = st; clr_err = clr;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (pc !== RST_PC || stack_depth !== 4'd0 || stack_empty !== 1'b1 ||
          stack_full !== 1'b0 || stack_err !== 1'b0) begin
         failures++;
         $display("FAIL reset: pc=%h depth=%0d empty=%b full=%b err=%b required pc=%h depth=0 empty=1 full=0 err=0",
                  pc, stack_depth, stack_empty, stack_full, stack_err, RST_PC);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_next();
      for (int i = 1; i <= 3; i++) begin
         apply(3'd0, '0, '0, 0, 0, 0);
         checks++;
         if (pc !== 18'(i) || pc !== m_pc || stack_empty !== 1'b1 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL next%0d: pc=%h empty=%b err=%b required pc=%h empty=1 err=0",
                     i, pc, stack_empty, stack_err, 18'(i));
         end
      end
   endtask

   task automatic test_wrap_brfl();
      apply(3'd1, 18'h3FFFF, '0, 0, 0, 0);
      apply(3'd0, '0, '0, 0, 0, 0);
      checks++;
      if (pc !== 18'h0) begin
         failures++; $display("FAIL wrap: pc=%h required 00000", pc);
      end
      apply(3'd3, 18'h00100, '0, 0, 0, 0);
      checks++;
      if (pc !== 18'h00001) begin
         failures++; $display("FAIL brfl_not_taken: pc=%h required 00001", pc);
      end
      apply(3'd3, 18'h00100, '0, 1, 0, 0);
      checks++;
      if (pc !== 18'h00100) begin
         failures++; $display("FAIL brfl_taken: pc=%h required 00100", pc);
      end
      apply(3'd2, '0, 18'h2ABCD, 0, 0, 0);
      checks++;
      if (pc !== 18'h2ABCD) begin
         failures++; $display("FAIL jr: pc=%h required 2abcd", pc);
      end
      apply(3'd7, 18'h1, 18'h2, 1, 0, 0);
      checks++;
      if (pc !== 18'h2ABCD) begin
         failures++; $display("FAIL undefined_op: pc=%h required 2abcd", pc);
      end
   endtask

   task automatic test_call_ret();
      apply(3'd1, 18'h00010, '0, 0, 0, 0);
      apply(3'd4, 18'h00200, '0, 0, 0, 0);
      checks++;
      if (pc !== 18'h00200 || stack_depth !== 4'd1 || stack_empty !== 1'b0) begin
         failures++;
         $display("FAIL call: pc=%h depth=%0d required pc=00200 depth=1", pc, stack_depth);
      end
      apply(3'd5, '0, '0, 0, 0, 0);
      checks++;
      if (pc !== 18'h00011 || stack_depth !== 4'd0 || stack_empty !== 1'b1) begin
         failures++;
         $display("FAIL ret: pc=%h depth=%0d required pc=00011 depth=0", pc, stack_depth);
      end
   endtask

   task automatic test_overflow();
      logic [AW-1:0] pc_before;
      for (int i = 1; i <= DEPTH; i++) begin
         apply(3'd4, 18'(32'h1000 + i * 16), '0, 0, 0, 0);
         checks++;
         if (stack_depth !== 4'(i) || stack_full !== (i == DEPTH) || pc !== m_pc) begin
            failures++;
            $display("FAIL call_fill%0d: depth=%0d full=%b pc=%h required depth=%0d full=%b pc=%h",
                     i, stack_depth, stack_full, pc, i, (i == DEPTH), m_pc);
         end
      end
      pc_before = pc;
      apply(3'd4, 18'h3F000, '0, 0, 0, 0);
      checks++;
      if (stack_err !== 1'b1 || stack_depth !== 4'd8 ||
          pc !== (TRAP_ON ? TRAP : pc_before)) begin
         failures++;
         $display("FAIL overflow: err=%b depth=%0d pc=%h required err=1 depth=8 pc=%h",
                  stack_err, stack_depth, pc, TRAP_ON ? TRAP : pc_before);
      end
      apply(3'd6, '0, '0, 0, 0, 1);
      checks++;
      if (stack_err !== 1'b0) begin
         failures++; $display("FAIL clr_err: err=%b required 0", stack_err);
      end
      // New error and clear in the same cycle: error must win.
      apply(3'd4, 18'h3F000, '0, 0, 0, 1);
      checks++;
      if (stack_err !== 1'b1 || stack_depth !== 4'd8) begin
         failures++;
         $display("FAIL err_beats_clr: err=%b depth=%0d required err=1 depth=8", stack_err, stack_depth);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         apply(3'd5, '0, '0, 0, 0, 0);
         checks++;
         if (pc !== m_pc || stack_depth !== 4'(i)) begin
            failures++;
            $display("FAIL drain%0d: pc=%h depth=%0d required pc=%h depth=%0d",
                     i, pc, stack_depth, m_pc, i);
         end
      end
      apply(3'd6, '0, '0, 0, 0, 1);
   endtask

   task automatic test_underflow_stall();
      logic [AW-1:0] pc_before;
      pc_before = pc;
      apply(3'd5, '0, '0, 0, 0, 0);
      checks++;
      if (stack_err !== 1'b1 || stack_depth !== 4'd0 || stack_empty !== 1'b1 ||
          pc !== (TRAP_ON ? TRAP : pc_before)) begin
         failures++;
         $display("FAIL underflow: err=%b depth=%0d pc=%h required err=1 depth=0 pc=%h",
                  stack_err, stack_depth, pc, TRAP_ON ? TRAP : pc_before);
      end
      pc_before = pc;
      apply(3'd4, 18'h12345, '0, 0, 1, 1);
      checks++;
      if (pc !== pc_before || stack_depth !== 4'd0 || stack_err !== 1'b1) begin
         failures++;
         $display("FAIL stall: pc=%h depth=%0d err=%b required pc=%h depth=0 err=1",
                  pc, stack_depth, stack_err, pc_before);
      end
      apply(3'd6, '0, '0, 0, 0, 1);
   endtask

   task automatic test_random();
      logic [2:0] op;
      for (int n = 0; n < 400; n++) begin
         op = 3'($urandom_range(0, 7));
         apply(op, 18'($urandom), 18'($urandom), 1'($urandom),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
         checks++;
         if (pc !== m_pc || stack_depth !== 4'(m_stk.size()) || stack_err !== m_err ||
             stack_full !== (m_stk.size() == DEPTH) || stack_empty !== (m_stk.size() == 0)) begin
            failures++;
            $display("FAIL random%0d op=%0d: pc=%h depth=%0d err=%b full=%b empty=%b required pc=%h depth=%0d err=%b",
                     n, op, pc, stack_depth, stack_err, stack_full, stack_empty,
                     m_pc, m_stk.size(), m_err);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      apply(3'd1, 18'h00400, '0, 0, 0, 0);
      for (int i = 0; i < 3; i++) apply(3'd4, 18'(32'h800 + i), '0, 0, 0, 0);
      checks++;
      if (stack_depth !== 4'd3) begin
         failures++; $display("FAIL pre_reset_depth: depth=%0d required 3", stack_depth);
      end
      @(negedge clk);
      pc_op = 3'd4; target_imm = 18'h0ABCD; stall = 1'b0; clr_err = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pc !== RST_PC || stack_depth !== 4'd0 || stack_empty !== 1'b1) begin
         failures++;
         $display("FAIL async_reset: pc=%h depth=%0d empty=%b required pc=%h depth=0 empty=1",
                  pc, stack_depth, stack_empty, RST_PC);
      end
      model_reset();
      @(negedge clk);
      pc_op = 3'd6;
      rst_n = 1'b1;
      apply(3'd6, '0, '0, 0, 0, 0);
      checks++;
      if (pc !== RST_PC || stack_depth !== 4'd0 || stack_err !== 1'b0) begin
         failures++;
         $display("FAIL post_reset: pc=%h depth=%0d err=%b required pc=%h depth=0 err=0",
                  pc, stack_depth, stack_err, RST_PC);
      end
   endtask

   initial begin
      test_reset();
      test_next();
      test_wrap_brfl();
      test_call_ret();
      test_overflow();
      test_underflow_stall();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
